// File: rtl/atm_pager_rdback.sv
// Readback responder for the ATM pager ports (xxF7 / x7F7): shadows every pager
// write per window and map, and answers Z80 IN cycles with the stored byte.
module atm_pager_rdback #(
  parameter logic [7:0] PORT_LO = 8'hF7,
  parameter logic [7:0] TIMEOUT = 8'd255
) (
  input  logic        fclk,
  input  logic        rst,
  input  logic        zpos,
  input  logic        zneg,
  input  logic [15:0] za,
  input  logic [7:0]  zd,
  input  logic        iorq_n,
  input  logic        rd_n,
  input  logic        m1_n,
  input  logic        atmF7_wr,
  input  logic        pent1m_ROM,
  input  logic        rdback_en,
  output logic [7:0]  rd_data,
  output logic        port_hit,
  output logic        timeout_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CAPT  = 2'd1,
    DRIVE = 2'd2
  } state_t;

  state_t state_reg, state_next;

  // Shadow entries are indexed by {window, map}
  logic [7:0] pg_reg  [8];
  logic       rnr_reg [8];
  logic       d7_reg  [8];

  logic [2:0] sel;
  logic [7:0] rb_byte;
  logic       hit_cond;
  logic       drive_release;
  logic       drive_timeout;
  logic [7:0] cnt_reg;

  logic       cap_en;
  logic       cnt_clr;
  logic       cnt_inc;
  logic       hit_set;
  logic       hit_clr;
  logic       err_set;

  logic       unused_ok;
  assign unused_ok = &{1'b0, zpos, za[13:12], za[10:8]};

  assign sel = {za[15:14], pent1m_ROM};

  assign hit_cond = zneg & rdback_en & ~iorq_n & ~rd_n & m1_n & (za[7:0] == PORT_LO);

  // Shadow write snoop, one register set per {window, map}
  for (genvar gi = 0; gi < 8; gi++) begin : g_shadow
    always_ff @(posedge fclk) begin
      if (rst) begin
        pg_reg[gi]  <= 8'h00;
        rnr_reg[gi] <= 1'b0;
        d7_reg[gi]  <= 1'b0;
      end else if (atmF7_wr && (sel == 3'(gi))) begin
        if (za[11]) begin
          pg_reg[gi]  <= ~{2'b11, zd[5:0]};
          rnr_reg[gi] <= zd[6];
          d7_reg[gi]  <= zd[7];
        end else begin
          pg_reg[gi]  <= ~zd;
          rnr_reg[gi] <= 1'b1;
        end
      end
    end
  end

  // Stored page is inverted; convert back to the format the port was written in
  always_comb begin
    rb_byte = ~pg_reg[sel];
    if (za[11]) begin
      rb_byte = {d7_reg[sel], rnr_reg[sel], ~pg_reg[sel][5:0]};
    end
  end

  assign drive_release = iorq_n | rd_n | ~rdback_en;
  assign drive_timeout = ~drive_release & (cnt_reg == TIMEOUT);

  always_ff @(posedge fclk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (hit_cond) state_next = CAPT;
      CAPT:    state_next = DRIVE;
      DRIVE:   if (drive_release || drive_timeout) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    cap_en  = 1'b0;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
    hit_set = 1'b0;
    hit_clr = 1'b0;
    err_set = 1'b0;
    case (state_reg)
      CAPT: begin
        cap_en  = 1'b1;
        cnt_clr = 1'b1;
        hit_set = 1'b1;
      end
      DRIVE: begin
        if (drive_release) begin
          hit_clr = 1'b1;
        end else if (drive_timeout) begin
          hit_clr = 1'b1;
          err_set = 1'b1;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      default: hit_clr = 1'b1;
    endcase
  end

  // Counter only advances while staying in DRIVE, so it stops at TIMEOUT
  always_ff @(posedge fclk) begin
    if (rst) begin
      rd_data     <= 8'h00;
      port_hit    <= 1'b0;
      timeout_err <= 1'b0;
      cnt_reg     <= 8'h00;
    end else begin
      if (cap_en) rd_data <= rb_byte;
      if (hit_set) begin
        port_hit <= 1'b1;
      end else if (hit_clr) begin
        port_hit <= 1'b0;
      end
      if (err_set) timeout_err <= 1'b1;
      if (cnt_clr) begin
        cnt_reg <= 8'h00;
      end else if (cnt_inc) begin
        cnt_reg <= cnt_reg + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_atm_pager_rdback.sv
// Bench for atm_pager_rdback: port-format shadow model checked every cycle,
// plus directed IN/OUT sequences with hand-computed readback bytes.
module tb_atm_pager_rdback;

  logic        fclk = 1'b0;
  logic        rst = 1'b1;
  logic        zpos = 1'b0;
  logic        zneg = 1'b0;
  logic [15:0] za = 16'h0000;
  logic [7:0]  zd = 8'h00;
  logic        iorq_n = 1'b1;
  logic        rd_n = 1'b1;
  logic        m1_n = 1'b1;
  logic        atmF7_wr = 1'b0;
  logic        pent1m_ROM = 1'b0;
  logic        rdback_en = 1'b1;
  logic [7:0]  rd_data;
  logic        port_hit;
  logic        timeout_err;

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  atm_pager_rdback dut (
    .fclk(fclk), .rst(rst), .zpos(zpos), .zneg(zneg), .za(za), .zd(zd),
    .iorq_n(iorq_n), .rd_n(rd_n), .m1_n(m1_n), .atmF7_wr(atmF7_wr),
    .pent1m_ROM(pent1m_ROM), .rdback_en(rdback_en),
    .rd_data(rd_data), .port_hit(port_hit), .timeout_err(timeout_err)
  );

  always #5 fclk = ~fclk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model keeps what was written, in the port's own (non-inverted) format
  logic [5:0] m_low [8];
  logic [1:0] m_hi  [8];
  logic       m_rnr [8];
  logic       m_d7  [8];
  int         m_phase;
  int         m_cnt;
  logic       e_hit, e_err;
  logic [7:0] e_data;

  function automatic logic [7:0] m_read(input logic [15:0] a, input logic map);
    int i;
    i = {a[15:14], map};
    return a[11] ? {m_d7[i], m_rnr[i], m_low[i]} : {m_hi[i], m_low[i]};
  endfunction

  always @(posedge fclk) begin
    int i;
    if (rst) begin
      m_phase = 0; m_cnt = 0; e_hit = 0; e_err = 0; e_data = 8'h00;
      for (int k = 0; k < 8; k++) begin
        m_low[k] = 6'h3F; m_hi[k] = 2'b11; m_rnr[k] = 0; m_d7[k] = 0;
      end
    end else begin
      case (m_phase)
        0: if (zneg && rdback_en && !iorq_n && !rd_n && m1_n && za[7:0] == 8'hF7) m_phase = 1;
        1: begin e_data = m_read(za, pent1m_ROM); e_hit = 1; m_cnt = 0; m_phase = 2; end
        default: begin
          if (iorq_n || rd_n || !rdback_en) begin
            m_phase = 0; e_hit = 0;
          end else if (m_cnt == 255) begin
            m_phase = 0; e_hit = 0; e_err = 1;
          end else begin
            m_cnt++;
          end
        end
      endcase
      if (atmF7_wr) begin
        i = {za[15:14], pent1m_ROM};
        m_low[i] = zd[5:0];
        if (za[11]) begin
          m_hi[i] = 2'b11; m_rnr[i] = zd[6]; m_d7[i] = zd[7];
        end else begin
          m_hi[i] = zd[7:6]; m_rnr[i] = 1;
        end
      end
    end
  end

  always @(negedge fclk) begin
    if (chk_en && !rst) begin
      chk("cyc_port_hit", {31'd0, port_hit}, {31'd0, e_hit});
      chk("cyc_timeout_err", {31'd0, timeout_err}, {31'd0, e_err});
      if (e_hit) chk("cyc_rd_data", {24'd0, rd_data}, {24'd0, e_data});
    end
  end

  task automatic cyc();
    @(posedge fclk);
    #2;
  endtask

  task automatic out_port(input logic [15:0] addr, input logic [7:0] d);
    za = addr; zd = d; atmF7_wr = 1'b1;
    cyc();
    atmF7_wr = 1'b0;
    cyc();
    $display("OUT %h <- %h", addr, d);
  endtask

  task automatic do_in(input logic [15:0] addr, input int hold, input bit wr_capt,
                       input logic [7:0] wr_val, output logic [7:0] got,
                       output int lat, output int hi_cycles);
    bit seen;
    za = addr; iorq_n = 1'b0; rd_n = 1'b0; m1_n = 1'b1; zneg = 1'b1;
    cyc();
    zneg = 1'b0;
    if (wr_capt) begin atmF7_wr = 1'b1; zd = wr_val; end
    lat = 1; got = 8'h00; seen = 0; hi_cycles = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge fclk);
      if (port_hit) begin got = rd_data; seen = 1; break; end
      lat++;
      cyc();
      atmF7_wr = 1'b0;
    end
    if (!seen) chk("hit_seen", 0, 1);
    else hi_cycles = 1;
    for (int i = 1; i < hold; i++) begin
      cyc();
      @(negedge fclk);
      if (port_hit) hi_cycles++;
    end
    cyc();
    iorq_n = 1'b1; rd_n = 1'b1;
    cyc();
    cyc();
    $display("IN  %h -> %h lat=%0d hi=%0d", addr, got, lat, hi_cycles);
  endtask

  logic [7:0] got;
  int lat, hi;

  initial begin
    repeat (3) cyc();
    rst = 1'b0;
    chk_en = 1'b1;
    @(negedge fclk);
    chk("rst_port_hit", {31'd0, port_hit}, 0);
    chk("rst_rd_data", {24'd0, rd_data}, 0);
    chk("rst_timeout_err", {31'd0, timeout_err}, 0);
    cyc();

    // Unwritten 1M-form window: d7=0, rnr=0, ~pg[5:0]=3F
    do_in(16'h3FF7, 4, 0, 8'h00, got, lat, hi);
    chk("t1_latency", lat, 2);
    chk("t1_data", {24'd0, got}, 32'h3F);
    chk("t1_hi_cycles", hi, 4);
    @(negedge fclk);
    chk("t1_released", {31'd0, port_hit}, 0);
    cyc();

    out_port(16'h7FF7, 8'hC5);
    do_in(16'h7FF7, 2, 0, 8'h00, got, lat, hi);
    chk("t2_map0", {24'd0, got}, 32'hC5);
    pent1m_ROM = 1'b1;
    do_in(16'h7FF7, 2, 0, 8'h00, got, lat, hi);
    chk("t2_map1", {24'd0, got}, 32'h3F);
    pent1m_ROM = 1'b0;

    // 4M write keeps d7=0 from the 1M write; low bits come from 9A
    out_port(16'hBFF7, 8'h45);
    out_port(16'hB7F7, 8'h9A);
    do_in(16'hB7F7, 2, 0, 8'h00, got, lat, hi);
    chk("t3_4m", {24'd0, got}, 32'h9A);
    do_in(16'hBFF7, 2, 0, 8'h00, got, lat, hi);
    chk("t3_1m", {24'd0, got}, 32'h5A);

    out_port(16'h37F7, 8'h11);
    do_in(16'h37F7, 2, 1, 8'h22, got, lat, hi);
    chk("t4_pre_write", {24'd0, got}, 32'h11);
    do_in(16'h37F7, 2, 0, 8'h00, got, lat, hi);
    chk("t4_post_write", {24'd0, got}, 32'h22);

    // Interrupt acknowledge at a pager address never hits
    za = 16'h00F7; iorq_n = 1'b0; rd_n = 1'b0; m1_n = 1'b0; zneg = 1'b1;
    cyc();
    zneg = 1'b0;
    repeat (4) cyc();
    @(negedge fclk);
    chk("t6_m1_nohit", {31'd0, port_hit}, 0);
    cyc();
    iorq_n = 1'b1; rd_n = 1'b1; m1_n = 1'b1;
    cyc();
    $display("INTACK 00F7 -> no hit");

    za = 16'h3FF7; iorq_n = 1'b0; rd_n = 1'b0; zneg = 1'b1;
    cyc();
    zneg = 1'b0;
    cyc();
    cyc();
    rdback_en = 1'b0;
    @(negedge fclk);
    chk("t6_still_driving", {31'd0, port_hit}, 1);
    cyc();
    @(negedge fclk);
    chk("t6_en_release", {31'd0, port_hit}, 0);
    chk("t6_no_err", {31'd0, timeout_err}, 0);
    cyc();
    iorq_n = 1'b1; rd_n = 1'b1; rdback_en = 1'b1;
    cyc();
    $display("IN  3FF7 rdback_en dropped mid-drive");

    // DRIVE cycles with count 0..TIMEOUT, then forced release
    do_in(16'h3FF7, 300, 0, 8'h00, got, lat, hi);
    chk("t5_hi_cycles", hi, 256);
    chk("t5_timeout_err", {31'd0, timeout_err}, 1);

    rst = 1'b1;
    cyc();
    rst = 1'b0;
    @(negedge fclk);
    chk("t7_err_cleared", {31'd0, timeout_err}, 0);
    cyc();
    do_in(16'h7FF7, 2, 0, 8'h00, got, lat, hi);
    chk("t7_shadow_cleared", {24'd0, got}, 32'h3F);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
